return_stack_ctrl: RTL and testbench
====================================

// Module: return_stack_ctrl
// PURPOSE
//  Sequential return-address stack controller for JAL/JS, downstream of the combinational stack-pointer update.
//  Owns the stack pointer register and entry count, and performs the data-RAM transactions.
//  Push (JAL) stores the return address; pop (JS) fetches the jump target. Stalls the pipeline while a RAM access is in flight.
// PARAMETERS
//  BASE_ADDR  32'h00000058  byte address of stack entry 0 (RAM word 22)
//  DEPTH      10            number of 32-bit entries (words 22..31, last entry 32'h0000007C)
// PORTS
//  clk             in   1   single clock, rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  push_i          in   1   JAL request (MemToReg[1])
//  pop_i           in   1   JS request (JUMP[1])
//  ret_addr_i      in   32  return address to push (PC+4)
//  stall_o         out  1   hold the pipeline (push_i/pop_i/ret_addr_i must be held stable)
//  target_o        out  32  last popped return address
//  target_valid_o  out  1   one-cycle pulse: target_o was updated
//  mem_req_o       out  1   RAM request, held until mem_ack_i
//  mem_we_o        out  1   1 = write (push), 0 = read (pop)
//  mem_addr_o      out  32  RAM byte address
//  mem_wdata_o     out  32  RAM write data
//  mem_rdata_i     in   32  RAM read data, valid when mem_ack_i=1
//  mem_ack_i       in   1   RAM completion, at least 0 wait cycles after request
//  sp_o            out  32  stack pointer = next free entry address
//  full_o          out  1   count == DEPTH
//  empty_o         out  1   count == 0
//  ovf_o           out  1   one-cycle pulse: push rejected, stack full
//  unf_o           out  1   one-cycle pulse: pop rejected, stack empty
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, sp=BASE_ADDR, count=0, target_o=0.
//   - All pulses and all mem_* outputs = 0; empty_o=1, full_o=0.
//   - Takes effect immediately, including mid-transaction; an in-flight request is abandoned.
//  FSM states IDLE, WRITE, READ. Requests are sampled only in IDLE.
//  Requests are ignored in WRITE/READ; the pipeline is stalled there.
//  IDLE, push_i=1 (has priority over pop_i when both are 1):
//   - !full: latch addr=sp and data=ret_addr_i, go to WRITE.
//   - full: ovf_o pulses next cycle; no RAM access; sp unchanged.
//  IDLE, pop_i=1 and push_i=0:
//   - !empty: latch addr=sp-4, go to READ.
//   - empty: unf_o pulses next cycle; no RAM access; target_valid_o stays 0.
//  WRITE: mem_req_o=1, mem_we_o=1, address and data stable.
//   - On mem_ack_i: sp+=4, count+=1, go to IDLE.
//  READ: mem_req_o=1, mem_we_o=0, address stable.
//   - On mem_ack_i: target_o<=mem_rdata_i, target_valid_o pulses next cycle, sp-=4, count-=1, go to IDLE.
//  mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are registered; they are 0 in IDLE.
//  stall_o = (state!=IDLE) | (IDLE & push_i & !full) | (IDLE & pop_i & !push_i & !empty).
//  Latency: with zero-wait ack, a push or pop occupies 2 cycles (request cycle + WRITE/READ).
//   - target_valid_o arrives on the first IDLE cycle after READ.
//  Width rules: sp arithmetic is 32-bit; sp range is BASE_ADDR..BASE_ADDR+4*DEPTH and never wraps.
//   - count is $clog2(DEPTH+1) bits.
//  target_o holds its value until the next successful pop.
// TESTING
//  1 Reset release -> sp_o=32'h58, empty_o=1, full_o=0, mem_req_o=0, target_o=0.
//  2 push ret_addr 32'h00400010, ack after 2 waits
//    -> single write at 32'h58 with data 32'h00400010, stall_o high throughout, then sp_o=32'h5C.
//  3 10 pushes, then an 11th push -> full_o=1, sp_o=32'h80, ovf_o pulses once, no 11th RAM write.
//  4 push A,B,C then 3 pops
//    -> reads at 32'h60, 32'h5C, 32'h58; target_o=C,B,A with one target_valid_o pulse per pop.
//    -> 4th pop: unf_o pulse, empty_o=1.
//  5 push_i=pop_i=1 in IDLE with count=1 -> write at 32'h5C, sp_o=32'h60, no read.
//  6 rst_n low in WRITE before ack -> mem_req_o=0 immediately; after release sp_o=32'h58, empty_o=1.

Source files
------------

// File: rtl/return_stack_ctrl.sv
// rtl/return_stack_ctrl.sv - return-address stack controller for JAL/JS with RAM handshake
module return_stack_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0058,
  parameter int          DEPTH     = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [31:0] ret_addr_i,
  output logic        stall_o,
  output logic [31:0] target_o,
  output logic        target_valid_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic [31:0] sp_o,
  output logic        full_o,
  output logic        empty_o,
  output logic        ovf_o,
  output logic        unf_o
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [31:0]    r_sp;
  logic [CW-1:0]  r_count;
  logic [31:0]    r_target;
  logic           r_target_valid;
  logic           r_mem_req;
  logic           r_mem_we;
  logic [31:0]    r_mem_addr;
  logic [31:0]    r_mem_wdata;
  logic           r_ovf;
  logic           r_unf;

  logic           w_idle;
  logic           w_full;
  logic           w_empty;
  logic           w_do_push;
  logic           w_do_pop;
  logic           w_ovf;
  logic           w_unf;
  logic           w_done;

  assign w_idle    = (r_state == S_IDLE);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  // push wins when both requests arrive together
  assign w_do_push = w_idle & push_i & ~w_full;
  assign w_do_pop  = w_idle & pop_i & ~push_i & ~w_empty;
  assign w_ovf     = w_idle & push_i & w_full;
  assign w_unf     = w_idle & pop_i & ~push_i & w_empty;
  assign w_done    = ~w_idle & mem_ack_i;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: requests only accepted in IDLE, RAM ack returns to IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_do_push) begin
          w_state_nxt = S_WRITE;
        end else if (w_do_pop) begin
          w_state_nxt = S_READ;
        end
      end
      S_WRITE, S_READ: begin
        if (mem_ack_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: registered RAM interface, stack pointer, count, target and pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp           <= BASE_ADDR;
      r_count        <= '0;
      r_target       <= '0;
      r_target_valid <= 1'b0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_ovf          <= 1'b0;
      r_unf          <= 1'b0;
    end else begin
      r_ovf          <= w_ovf;
      r_unf          <= w_unf;
      r_target_valid <= (r_state == S_READ) & mem_ack_i;
      if (w_do_push) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b1;
        r_mem_addr  <= r_sp;
        r_mem_wdata <= ret_addr_i;
      end else if (w_do_pop) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= r_sp - 32'd4;
        r_mem_wdata <= '0;
      end else if (w_done) begin
        r_mem_req   <= 1'b0;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= '0;
        r_mem_wdata <= '0;
        if (r_state == S_WRITE) begin
          r_sp    <= r_sp + 32'd4;
          r_count <= r_count + 1'b1;
        end else begin
          r_target <= mem_rdata_i;
          r_sp     <= r_sp - 32'd4;
          r_count  <= r_count - 1'b1;
        end
      end
    end
  end

  assign stall_o        = ~w_idle | w_do_push | w_do_pop;
  assign target_o       = r_target;
  assign target_valid_o = r_target_valid;
  assign mem_req_o      = r_mem_req;
  assign mem_we_o       = r_mem_we;
  assign mem_addr_o     = r_mem_addr;
  assign mem_wdata_o    = r_mem_wdata;
  assign sp_o           = r_sp;
  assign full_o         = w_full;
  assign empty_o        = w_empty;
  assign ovf_o          = r_ovf;
  assign unf_o          = r_unf;

endmodule

// File: tb/tb_return_stack_ctrl.sv
// tb/tb_return_stack_ctrl.sv - self-checking bench for return_stack_ctrl
module tb_return_stack_ctrl;

  logic        clk;
  logic        rst_n;
  logic        push_i;
  logic        pop_i;
  logic [31:0] ret_addr_i;
  logic        stall_o;
  logic [31:0] target_o;
  logic        target_valid_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic [31:0] sp_o;
  logic        full_o;
  logic        empty_o;
  logic        ovf_o;
  logic        unf_o;

  return_stack_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .push_i         (push_i),
    .pop_i          (pop_i),
    .ret_addr_i     (ret_addr_i),
    .stall_o        (stall_o),
    .target_o       (target_o),
    .target_valid_o (target_valid_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i),
    .mem_ack_i      (mem_ack_i),
    .sp_o           (sp_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .ovf_o          (ovf_o),
    .unf_o          (unf_o)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] tgt_q[$];
  logic [31:0] model_stk[$];
  logic [31:0] ram[0:63];

  int n_tests = 0;
  int n_fail  = 0;
  int wait_cfg = 0;
  int wcnt = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int ovf_cnt = 0;
  int unf_cnt = 0;
  int tv_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RAM model: acks after wait_cfg cycles and scores each completed transaction
  always @(negedge clk) begin
    if (mem_req_o) begin
      if (wcnt >= wait_cfg) begin
        txn_t t;
        mem_ack_i = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_txn", 32'd1, 32'd0);
        end else begin
          t = exp_q.pop_front();
          check("txn_we", {31'd0, mem_we_o}, {31'd0, t.we});
          check("txn_addr", mem_addr_o, t.addr);
          if (t.we) check("txn_wdata", mem_wdata_o, t.data);
        end
        if (mem_we_o) begin
          ram[mem_addr_o[7:2]] = mem_wdata_o;
          wr_cnt++;
        end else begin
          mem_rdata_i = ram[mem_addr_o[7:2]];
          rd_cnt++;
        end
        wcnt = 0;
      end else begin
        mem_ack_i = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
      wcnt        = 0;
    end
  end

  // Output monitor: pulse counters and popped-target scoreboard
  always @(negedge clk) begin
    if (ovf_o) ovf_cnt++;
    if (unf_o) unf_cnt++;
    if (target_valid_o) begin
      tv_cnt++;
      if (tgt_q.size() == 0) begin
        check("unexpected_target", 32'd1, 32'd0);
      end else begin
        check("target", target_o, tgt_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    push_i     = 1'b0;
    pop_i      = 1'b0;
    ret_addr_i = '0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    tgt_q.delete();
    model_stk.delete();
    wait_cfg = 0;
    rst_n    = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!stall_o) break;
      cycles++;
    end
    if (cycles >= 40) check("stall_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_push(input logic [31:0] val, input int waits, output int cycles);
    wait_cfg = waits;
    if (model_stk.size() < 10) begin
      exp_q.push_back('{1'b1, 32'h58 + 32'(4 * model_stk.size()), val});
      model_stk.push_back(val);
    end
    ret_addr_i = val;
    push_i     = 1'b1;
    @(posedge clk);
    #1 push_i = 1'b0;
    wait_idle(cycles);
  endtask

  task automatic do_pop(input int waits, output int cycles);
    wait_cfg = waits;
    if (model_stk.size() > 0) begin
      exp_q.push_back('{1'b0, 32'h58 + 32'(4 * (model_stk.size() - 1)), 32'd0});
      tgt_q.push_back(model_stk.pop_back());
    end
    pop_i = 1'b1;
    @(posedge clk);
    #1 pop_i = 1'b0;
    wait_idle(cycles);
  endtask

  initial begin
    int cyc;
    int wr0, rd0, ovf0, unf0, tv0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    for (int i = 0; i < 64; i++) ram[i] = '0;

    // 1: reset state
    do_reset();
    check("rst_sp", sp_o, 32'h58);
    check("rst_empty", {31'd0, empty_o}, 32'd1);
    check("rst_full", {31'd0, full_o}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_target", target_o, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);

    // 2: single push with two wait states
    wr0 = wr_cnt;
    do_push(32'h0040_0010, 2, cyc);
    check("push_stall_cycles", cyc, 32'd3);
    check("push_sp", sp_o, 32'h5C);
    check("push_wr_count", wr_cnt - wr0, 32'd1);
    check("push_mem_req_idle", {31'd0, mem_req_o}, 32'd0);

    // 3: fill to DEPTH, then one rejected push
    do_reset();
    for (int i = 0; i < 10; i++) begin
      do_push(32'h1000_0000 + 32'(i), 0, cyc);
      check("fill_stall_cycles", cyc, 32'd1);
    end
    check("fill_full", {31'd0, full_o}, 32'd1);
    check("fill_sp", sp_o, 32'h80);
    wr0  = wr_cnt;
    ovf0 = ovf_cnt;
    do_push(32'hDEAD_BEEF, 0, cyc);
    repeat (2) @(negedge clk);
    check("ovf_stall_cycles", cyc, 32'd0);
    check("ovf_pulses", ovf_cnt - ovf0, 32'd1);
    check("ovf_no_write", wr_cnt - wr0, 32'd0);
    check("ovf_sp", sp_o, 32'h80);
    check("ovf_full", {31'd0, full_o}, 32'd1);

    // 4: push A,B,C then pop them back, then underflow
    do_reset();
    do_push(32'hAAAA_0004, 1, cyc);
    do_push(32'hBBBB_0008, 0, cyc);
    do_push(32'hCCCC_000C, 3, cyc);
    check("abc_sp", sp_o, 32'h64);
    rd0 = rd_cnt;
    tv0 = tv_cnt;
    do_pop(1, cyc);
    check("pop1_stall_cycles", cyc, 32'd2);
    check("pop1_sp", sp_o, 32'h60);
    do_pop(0, cyc);
    check("pop2_sp", sp_o, 32'h5C);
    do_pop(2, cyc);
    check("pop3_sp", sp_o, 32'h58);
    @(negedge clk);
    check("pop_reads", rd_cnt - rd0, 32'd3);
    check("pop_tvalid_pulses", tv_cnt - tv0, 32'd3);
    check("pop_tgt_drained", tgt_q.size(), 32'd0);
    check("pop_target_hold", target_o, 32'hAAAA_0004);
    unf0 = unf_cnt;
    tv0  = tv_cnt;
    do_pop(0, cyc);
    repeat (2) @(negedge clk);
    check("unf_pulses", unf_cnt - unf0, 32'd1);
    check("unf_no_tvalid", tv_cnt - tv0, 32'd0);
    check("unf_empty", {31'd0, empty_o}, 32'd1);
    check("unf_reads", rd_cnt - rd0, 32'd3);
    check("unf_target_hold", target_o, 32'hAAAA_0004);

    // 5: simultaneous push and pop with one entry -> push wins
    do_reset();
    do_push(32'h0000_1111, 0, cyc);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    exp_q.push_back('{1'b1, 32'h5C, 32'h0000_2222});
    model_stk.push_back(32'h0000_2222);
    ret_addr_i = 32'h0000_2222;
    push_i     = 1'b1;
    pop_i      = 1'b1;
    @(posedge clk);
    #1;
    push_i = 1'b0;
    pop_i  = 1'b0;
    wait_idle(cyc);
    check("both_sp", sp_o, 32'h60);
    check("both_no_read", rd_cnt - rd0, 32'd0);
    check("both_one_write", wr_cnt - wr0, 32'd1);

    // 6: reset in WRITE before ack
    do_reset();
    wait_cfg   = 5;
    ret_addr_i = 32'h0000_3333;
    push_i     = 1'b1;
    @(posedge clk);
    #1 push_i = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_mem_req", {31'd0, mem_req_o}, 32'd1);
    check("mid_stall", {31'd0, stall_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("mid_rst_mem_we", {31'd0, mem_we_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_sp", sp_o, 32'h58);
    check("mid_rst_empty", {31'd0, empty_o}, 32'd1);
    check("mid_rst_stall", {31'd0, stall_o}, 32'd0);
    check("mid_rst_no_pending", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
